dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_pkg.sv | 35 +++
 rtl/dmem_lane_align.sv | 41 ++++
 rtl/dmem_bridge.sv | 120 ++++++++++++
 tb/tb_dmem_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the core data-memory bridge: FSM states, access
// types, funct3 width codes and the alignment rule.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the access must be rejected: illegal code or misaligned.
    function automatic logic access_rejected(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: access_rejected = 1'b0;
            F3_H, F3_HU: access_rejected = lo[0];
            F3_W:        access_rejected = (lo != 2'b00);
            default:     access_rejected = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication + byte enables, and load
// extraction with sign/zero extension.
module dmem_lane_align
    import dmem_bridge_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   addr_lo_i,
    input  logic [2:0]   width_i,
    input  logic [W-1:0] st_data_i,
    input  logic [W-1:0] ld_rdata_i,
    output logic [3:0]   be_o,
    output logic [W-1:0] st_wdata_o,
    output logic [W-1:0] ld_data_o
);

    logic [W-1:0] shifted;

    always_comb begin
        shifted    = ld_rdata_i >> {addr_lo_i, 3'b000};
        be_o       = 4'b1111;
        st_wdata_o = st_data_i;
        ld_data_o  = shifted;
        case (width_i)
            F3_B, F3_BU: begin
                be_o       = 4'b0001 << addr_lo_i;
                st_wdata_o = {(W/8){st_data_i[7:0]}};
                ld_data_o  = (width_i == F3_B) ? {{(W-8){shifted[7]}}, shifted[7:0]}
                                               : {{(W-8){1'b0}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be_o       = 4'b0011 << addr_lo_i;
                st_wdata_o = {(W/16){st_data_i[15:0]}};
                ld_data_o  = (width_i == F3_H) ? {{(W-16){shifted[15]}}, shifted[15:0]}
                                               : {{(W-16){1'b0}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Core memory-stage to req/gnt/rvalid bus bridge. One access in flight;
// misaligned or illegal accesses are rejected without touching the bus.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         a_reset_n,
    input  logic [W-1:0] data_addr,
    input  logic [W-1:0] data_out,
    input  logic [1:0]   opType,
    input  logic [2:0]   width,
    input  logic         stall_mmu,
    output logic [W-1:0] data_in,
    output logic         mem_stall,
    output logic         misalign,
    output logic         bus_req,
    output logic         bus_we,
    output logic [W-1:0] bus_addr,
    output logic [3:0]   bus_be,
    output logic [W-1:0] bus_wdata,
    input  logic         bus_gnt,
    input  logic         bus_rvalid,
    input  logic [W-1:0] bus_rdata
);

    state_e       state_q;
    logic         req_q, we_q, mis_q;
    logic [W-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]   be_q;
    logic [1:0]   lo_q;
    logic [2:0]   wid_q;

    logic         access_v, reject;
    logic [1:0]   al_lo;
    logic [2:0]   al_wid;
    logic [3:0]   al_be;
    logic [W-1:0] al_wdata, al_ldata;

    assign access_v = (opType == OP_LOAD) || (opType == OP_STORE);
    assign reject   = access_rejected(width, data_addr[1:0]);

    // Steer from live core inputs while idle, from the latched access afterwards.
    assign al_lo  = (state_q == ST_IDLE) ? data_addr[1:0] : lo_q;
    assign al_wid = (state_q == ST_IDLE) ? width : wid_q;

    dmem_lane_align #(.W(W)) u_align (
        .addr_lo_i  (al_lo),
        .width_i    (al_wid),
        .st_data_i  (data_out),
        .ld_rdata_i (bus_rdata),
        .be_o       (al_be),
        .st_wdata_o (al_wdata),
        .ld_data_o  (al_ldata)
    );

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            lo_q    <= '0;
            wid_q   <= '0;
        end else begin
            mis_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (access_v) begin
                    lo_q  <= data_addr[1:0];
                    wid_q <= width;
                    if (reject) begin
                        mis_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= (opType == OP_STORE);
                        addr_q  <= {data_addr[W-1:2], 2'b00};
                        be_q    <= al_be;
                        wdata_q <= al_wdata;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: if (bus_gnt) begin
                    req_q <= 1'b0;
                    if (we_q) begin
                        state_q <= ST_DONE;
                    end else if (bus_rvalid) begin
                        rdata_q <= al_ldata;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: if (bus_rvalid) begin
                    rdata_q <= al_ldata;
                    state_q <= ST_DONE;
                end
                ST_DONE: if (!stall_mmu) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_stall = ((state_q == ST_IDLE) && access_v) ||
                       (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign misalign  = mis_q;
    assign data_in   = rdata_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized accesses against an arithmetic reference of the
// lane/extension rules and the cycle-level handshake.
module tb_dmem_bridge;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          a_reset_n;
    logic [W-1:0]  data_addr, data_out, data_in;
    logic [1:0]    opType;
    logic [2:0]    width;
    logic          stall_mmu, mem_stall, misalign;
    logic          bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [W-1:0]  bus_addr, bus_wdata, bus_rdata;
    logic [3:0]    bus_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.W(W)) dut (
        .clk(clk), .a_reset_n(a_reset_n),
        .data_addr(data_addr), .data_out(data_out), .opType(opType), .width(width),
        .stall_mmu(stall_mmu), .data_in(data_in), .mem_stall(mem_stall), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules written directly from the access-size definitions.
    function automatic logic ref_reject(input logic [2:0] f, input logic [31:0] a);
        int bytes;
        case (f)
            3'd0, 3'd4: bytes = 1;
            3'd1, 3'd5: bytes = 2;
            3'd2:       bytes = 4;
            default:    return 1'b1;
        endcase
        return (int'(a[1:0]) % bytes) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
        int bytes = (f == 3'd2) ? 4 : ((f == 3'd1 || f == 3'd5) ? 2 : 1);
        logic [3:0] be = '0;
        for (int i = 0; i < bytes; i++) be[int'(a[1:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            if (f == 3'd2)                  r[i*8 +: 8] = d[i*8 +: 8];
            else if (f == 3'd1 || f == 3'd5) r[i*8 +: 8] = d[(i%2)*8 +: 8];
            else                            r[i*8 +: 8] = d[7:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int sh = 8 * int'(a[1:0]);
        longint v;
        case (f)
            3'd0: v = longint'($signed(rd[sh +: 8]));
            3'd4: v = longint'(rd[sh +: 8]);
            3'd1: v = longint'($signed(rd[sh +: 16]));
            3'd5: v = longint'(rd[sh +: 16]);
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    // Core-side inputs are don't-care while the bridge is busy.
    task automatic scramble();
        opType    = 2'($urandom_range(0, 3));
        width     = 3'($urandom_range(0, 7));
        data_addr = $urandom;
        data_out  = $urandom;
    endtask

    task automatic access(input logic [1:0] op, input logic [2:0] f, input logic [31:0] addr,
                          input logic [31:0] sd, input int gdly, input int rdly,
                          input logic [31:0] rd, input int hold);
        int stalls = 0;
        logic mis = ref_reject(f, addr);
        logic ld = (op == 2'b01);
        logic [31:0] exp_din = 32'h0;
        opType = op; width = f; data_addr = addr; data_out = sd;
        stall_mmu = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
        @(negedge clk);
        stalls += int'(mem_stall);
        chk("idle_stall", mem_stall, 1);
        chk("idle_req", bus_req, 0);
        if (!mis) begin
            for (int g = 0; g <= gdly; g++) begin
                @(posedge clk); #1;
                scramble();
                bus_gnt    = (g == gdly);
                bus_rvalid = (g == gdly) ? (ld && rdly == 0) : 1'($urandom_range(0, 1));
                bus_rdata  = (bus_gnt && bus_rvalid) ? rd : $urandom;
                @(negedge clk);
                stalls += int'(mem_stall);
                chk("req_req", bus_req, 1);
                chk("req_addr", bus_addr, {addr[31:2], 2'b00});
                chk("req_we", bus_we, !ld);
                chk("req_be", bus_be, ref_be(f, addr));
                if (!ld) chk("req_wdata", bus_wdata, ref_wdata(f, sd));
            end
            if (ld) for (int w = 1; w <= rdly; w++) begin
                @(posedge clk); #1;
                scramble();
                bus_gnt    = 1'b0;
                bus_rvalid = (w == rdly);
                bus_rdata  = (w == rdly) ? rd : $urandom;
                @(negedge clk);
                stalls += int'(mem_stall);
                chk("wait_req", bus_req, 0);
            end
            if (ld) exp_din = ref_load(f, addr, rd);
        end
        for (int d = 0; d <= hold; d++) begin
            @(posedge clk); #1;
            scramble();
            bus_gnt    = 1'b0;
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            stall_mmu  = (d < hold);
            @(negedge clk);
            stalls += int'(mem_stall);
            chk("done_stall", mem_stall, 0);
            chk("done_req", bus_req, 0);
            chk("done_misalign", misalign, mis && d == 0);
            if (ld || mis) chk("done_data_in", data_in, exp_din);
        end
        chk("stall_cycles", stalls, mis ? 1 : (2 + gdly + (ld ? rdly : 0)));
        @(posedge clk); #1;
        opType = 2'b00; bus_rvalid = 1'b0; bus_gnt = 1'b0; stall_mmu = 1'b0;
    endtask

    initial begin
        a_reset_n = 1'b0; opType = 2'b00; width = 3'b0; data_addr = '0; data_out = '0;
        stall_mmu = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk); #1;
        opType = 2'b01;
        @(negedge clk);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_stall_valid", mem_stall, 1);
        opType = 2'b00;
        #1 chk("rst_stall_none", mem_stall, 0);
        @(posedge clk); #1;
        a_reset_n = 1'b1;

        // SW 0x100, grant on the second REQ cycle
        access(2'b10, 3'd2, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0, 0);
        // LB / LBU 0x103 with grant and rvalid together
        access(2'b01, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80123456, 0);
        chk("lb_value", data_in, 32'hFFFFFF80);
        access(2'b01, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80123456, 0);
        chk("lbu_value", data_in, 32'h00000080);
        // SH 0x1234 to 0x102
        access(2'b10, 3'd1, 32'h102, 32'h00001234, 0, 0, 32'h0, 0);
        // LW misaligned
        access(2'b01, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0, 1);
        // LW, rvalid 4 cycles after grant, core holds DONE for 2 cycles
        access(2'b01, 3'd2, 32'h204, 32'h0, 0, 4, 32'hCAFEF00D, 2);
        // Illegal width code
        access(2'b10, 3'd3, 32'h300, 32'h55, 0, 0, 32'h0, 0);

        // Reset while waiting for read data, then a stray rvalid
        opType = 2'b01; width = 3'd2; data_addr = 32'h400;
        @(posedge clk); #1;
        bus_gnt = 1'b1; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        bus_gnt = 1'b0; opType = 2'b00;
        @(negedge clk);
        chk("wait_stall", mem_stall, 1);
        a_reset_n = 1'b0;
        #1;
        chk("midrst_stall", mem_stall, 0);
        chk("midrst_req", bus_req, 0);
        chk("midrst_data_in", data_in, 0);
        @(posedge clk); #1;
        a_reset_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_rv_stall", mem_stall, 0);
        chk("late_rv_req", bus_req, 0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_data_in", data_in, 0);
        chk("late_rv_stall2", mem_stall, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                opType = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                data_addr = $urandom; width = 3'($urandom_range(0, 7));
                bus_rvalid = 1'($urandom_range(0, 1)); bus_gnt = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("idle_none_stall", mem_stall, 0);
                chk("idle_none_req", bus_req, 0);
                @(posedge clk); #1;
                opType = 2'b00; bus_rvalid = 1'b0; bus_gnt = 1'b0;
            end else begin
                logic [31:0] a = $urandom;
                if ($urandom_range(0, 1) == 0) a[0] = 1'b0;
                if ($urandom_range(0, 2) == 0) a[1] = 1'b0;
                access(2'($urandom_range(1, 2)), 3'($urandom_range(0, 7)), a, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
